regfile_mem_sequencer: RTL and testbench
========================================

# regfile_mem_sequencer

Multi-register transfer sequencer for the multicycle processor. It executes block store and block load operations between the 8-entry register file and data memory. On a start pulse it walks a register mask in ascending index order and issues one memory request per selected register. For stores it reads the register file and drives memory write data. For loads it captures memory read data and writes it back through the register file write port. The control unit starts it and waits for `done`, then writes `end_addr` back as the updated base.

## Interface
Parameters:
- `W`, 32, data and address width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- `dir`  in  1  0 = store (reg→mem), 1 = load (mem→reg); captured on start
- `reg_mask`  in  8  bit i selects register i; captured on start
- `base_addr`  in  W  first memory address; captured on start
- `busy`  out  1  high from the cycle after an accepted start until `done`
- `done`  out  1  one-cycle completion pulse
- `end_addr`  out  W  base + 4·N, where N is the number of transferred registers; valid from `done` and held until the next start
- `rf_add`  out  3  register index, driven to both the read address and the write address of the register file
- `rf_rdata`  in  W  register file read data (combinational read of `rf_add`)
- `rf_we`  out  1  register file write enable
- `rf_wdata`  out  W  register file write data
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  1 = write beat
- `mem_addr`  out  W  beat address
- `mem_wdata`  out  W  store data
- `mem_ack`  in  1  beat accepted at this rising edge
- `mem_rdata`  in  W  load data, valid with `mem_ack`

## Operation
- States:
  - IDLE
  - REQ: a memory beat is outstanding
  - WB: load writeback
  - DONE
- IDLE + start → the mask, dir and base are latched.
  - If any bit is set: go to REQ for the lowest set index.
  - If the mask is empty: go to DONE.
- REQ:
  - `mem_req`=1, `mem_we`=~dir, `mem_addr`=current address, `rf_add`=current index.
  - Store: `mem_wdata`=`rf_rdata`, combinational pass-through.
  - Request signals stay stable until `mem_ack`; `mem_req` never drops without an ack.
- REQ + ack:
  - The address advances by 4, modulo 2^W, so it wraps silently.
  - The index's mask bit is cleared.
  - Store: go to REQ for the next set bit, or to DONE if none remain.
  - Load: `mem_rdata` is registered into `rf_wdata`; go to WB.
- WB:
  - `rf_we`=1 for exactly one cycle with `rf_add`=index and `rf_wdata`=the captured data.
  - Then go to REQ for the next set bit, or to DONE if none remain.
- DONE: `done`=1 and `busy`=0 for one cycle; `end_addr` is updated; go to IDLE.
- `start` while not in IDLE is ignored; the latched operands do not change.
- `mem_ack` outside REQ is ignored.
- Reset (async, any state):
  - State goes to IDLE.
  - `busy`, `done`, `rf_we`, `mem_req`, `mem_we` = 0.
  - `rf_add` = 0; `rf_wdata`, `mem_addr`, `mem_wdata`, `end_addr` = 0.
  - An outstanding beat is abandoned, with no register write.

## Timing
- An accepted start at edge k puts the first REQ (or DONE, for an empty mask) in cycle k+1.
- Store: 1 cycle per beat when `mem_ack` is held high. `done` comes N+1 cycles after start.
- Load: 2 cycles per beat minimum (REQ, WB). `done` comes 2N+1 cycles after start.
- Each cycle of `mem_ack` low in REQ adds exactly one cycle.
- `rf_we` is never asserted together with `mem_req`.
- All outputs are registered except `mem_wdata` in store REQ, which is combinational from `rf_rdata`.

## Configuration
- `REG7_XFER_EN` defined: mask bit 7 (PC register) is honoured in both directions.
- `REG7_XFER_EN` undefined: mask bit 7 is forced to 0 at capture.
  - No beat is issued for register 7.
  - N excludes register 7.
  - A mask of only 0x80 completes like an empty mask.

## Test plan
- Store, mask 0x0B, base 0x100, ack tied high:
  - beats at 0x100/0x104/0x108 with `rf_add` 0/1/3;
  - `mem_wdata` equals the register contents;
  - `done` at cycle 4 after start; `end_addr`=0x10C.
- Load, mask 0x41, base 0x200, rdata 0xDEADBEEF then 0x12345678:
  - `rf_we` pulses write R0=0xDEADBEEF and R6=0x12345678;
  - `done` at cycle 5; `end_addr`=0x208.
- Empty mask 0x00, base 0x40:
  - `done` one cycle after start; no `mem_req`; `end_addr`=0x40.
- Store mask 0x03, base 0xFFFFFFFC; ack low for 3 cycles on the first beat; `start` pulsed while busy:
  - `mem_req`, `mem_addr` and `mem_wdata` stay stable during the stall;
  - the second address is 0x00000000; `end_addr`=0x4;
  - the extra start has no effect.
- Reset asserted in WB of a load, mask 0x06:
  - all outputs are 0 immediately; no `rf_we`;
  - a new start after release runs normally.
- Store, mask 0xFF, base 0:
  - with `REG7_XFER_EN`: 8 beats, `end_addr`=0x20;
  - without it: 7 beats, `end_addr`=0x1C.

Source files
------------

// File: rtl/regfile_mem_sequencer.sv
// Block store/load sequencer between the 8-entry register file and data memory.
// Optional build macro REG7_XFER_EN: when defined, mask bit 7 (PC) is transferred too.
module regfile_mem_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  input  logic [7:0]   reg_mask,
  input  logic [W-1:0] base_addr,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] end_addr,
  output logic [2:0]   rf_add,
  input  logic [W-1:0] rf_rdata,
  output logic         rf_we,
  output logic [W-1:0] rf_wdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef REG7_XFER_EN
  localparam logic [7:0] CAP_MASK = 8'hFF;
`else
  localparam logic [7:0] CAP_MASK = 8'h7F;
`endif

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  state_t       state_r, state_s;
  logic [7:0]   mask_r, mask_s, cap_mask_s, left_s;
  logic         dir_r, dir_s;
  logic [W-1:0] addr_r, addr_s;
  logic [2:0]   idx_r, idx_s;
  logic [W-1:0] rdata_r, rdata_s;
  logic [W-1:0] end_r, end_s;
  logic         busy_r, busy_s, done_r, done_s;
  logic         mem_req_r, mem_req_s, mem_we_r, mem_we_s, rf_we_r, rf_we_s;

  // State and datapath registers; an async reset abandons any outstanding beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      mask_r    <= 8'd0;
      dir_r     <= 1'b0;
      addr_r    <= '0;
      idx_r     <= 3'd0;
      rdata_r   <= '0;
      end_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
      rf_we_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      mask_r    <= mask_s;
      dir_r     <= dir_s;
      addr_r    <= addr_s;
      idx_r     <= idx_s;
      rdata_r   <= rdata_s;
      end_r     <= end_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      mem_req_r <= mem_req_s;
      mem_we_r  <= mem_we_s;
      rf_we_r   <= rf_we_s;
    end
  end

  // Next-state and datapath update: the mask shrinks one bit per accepted beat.
  always_comb begin
    state_s    = state_r;
    mask_s     = mask_r;
    dir_s      = dir_r;
    addr_s     = addr_r;
    idx_s      = idx_r;
    rdata_s    = rdata_r;
    end_s      = end_r;
    cap_mask_s = reg_mask & CAP_MASK;
    left_s     = mask_r & ~(8'd1 << idx_r);
    case (state_r)
      S_IDLE: begin
        if (start) begin
          mask_s  = cap_mask_s;
          dir_s   = dir;
          addr_s  = base_addr;
          idx_s   = lowest_set(cap_mask_s);
          state_s = (|cap_mask_s) ? S_REQ : S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          addr_s = addr_r + W'(32'd4);
          mask_s = left_s;
          if (dir_r) begin
            rdata_s = mem_rdata;
            state_s = S_WB;
          end else if (|left_s) begin
            idx_s   = lowest_set(left_s);
            state_s = S_REQ;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          state_s = S_REQ;
        end
      end
      S_WB: begin
        if (|mask_r) begin
          idx_s   = lowest_set(mask_r);
          state_s = S_REQ;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    if (state_s == S_DONE) begin
      end_s = addr_s;
    end else begin
      end_s = end_r;
    end
  end

  // Output decode from the next state so every control output is registered.
  always_comb begin
    busy_s    = 1'b0;
    done_s    = 1'b0;
    mem_req_s = 1'b0;
    mem_we_s  = 1'b0;
    rf_we_s   = 1'b0;
    case (state_s)
      S_REQ: begin
        busy_s    = 1'b1;
        mem_req_s = 1'b1;
        mem_we_s  = ~dir_s;
      end
      S_WB: begin
        busy_s  = 1'b1;
        rf_we_s = 1'b1;
      end
      S_DONE:  done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign end_addr  = end_r;
  assign rf_add    = idx_r;
  assign rf_we     = rf_we_r;
  assign rf_wdata  = rdata_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  // Store data flows straight from the register file read port during a write beat.
  assign mem_wdata = (mem_req_r && mem_we_r) ? rf_rdata : '0;

endmodule

// File: tb/tb_regfile_mem_sequencer.sv
// Scoreboard bench for regfile_mem_sequencer: directed scenarios plus randomized transfers.
module tb_regfile_mem_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, dir;
  logic [7:0]  reg_mask;
  logic [31:0] base_addr, end_addr, rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, rf_we, mem_req, mem_we, mem_ack;
  logic [2:0]  rf_add;

  regfile_mem_sequencer #(.W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .reg_mask(reg_mask),
    .base_addr(base_addr), .busy(busy), .done(done), .end_addr(end_addr),
    .rf_add(rf_add), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [2:0] idx; logic [31:0] wdata; } beat_t;
  typedef struct { logic [2:0] idx; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] end_a; int unsigned start_cyc; int unsigned lat; } done_t;

  beat_t       beat_q[$];
  wr_t         wr_q[$];
  done_t       done_q[$];
  int          stall_q[$];
  logic [31:0] regs[8];
  logic [31:0] ref_regs[8];
  bit          preload;
  bit          mon_en;
  int          done_cnt = 0;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: combinational read, write on rf_we.
  always @(posedge clk) begin
    if (rf_we) regs[rf_add] <= rf_wdata;
    else if (preload) regs <= ref_regs;
  end
  assign rf_rdata = regs[rf_add];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
    if (a == 32'h0000_0204) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory responder: per-beat stall counts come from the stimulus, ack noise elsewhere.
  initial begin
    bit in_beat;
    int stall;
    in_beat = 1'b0; stall = 0; mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req && rst) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          stall = 0;
          if (stall_q.size() > 0) stall = stall_q.pop_front();
        end
        if (stall > 0) begin
          mem_ack = 1'b0; mem_rdata = $urandom; stall--;
        end else begin
          mem_ack = 1'b1; mem_rdata = mem_read(mem_addr); in_beat = 1'b0;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; in_beat = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat, write or completion.
  initial begin
    logic prev_stall, p_we;
    logic [31:0] p_addr, p_wd;
    logic [2:0] p_idx;
    beat_t b; wr_t w; done_t d;
    prev_stall = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wd = 32'h0; p_idx = 3'd0;
    forever begin
      @(negedge clk); #1;
      if (mon_en && rst) begin
        if (prev_stall) begin
          chk("stall_req", mem_req, 1);
          chk("stall_addr", mem_addr, p_addr);
          chk("stall_wdata", mem_wdata, p_wd);
          chk("stall_we", mem_we, p_we);
          chk("stall_idx", rf_add, p_idx);
        end
        if (mem_req && mem_ack) begin
          chk("beat_expected", beat_q.size() > 0, 1);
          chk("beat_busy", busy, 1);
          if (beat_q.size() > 0) begin
            b = beat_q.pop_front();
            chk("beat_addr", mem_addr, b.addr);
            chk("beat_we", mem_we, b.we);
            chk("beat_idx", rf_add, b.idx);
            if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
          end
        end
        if (rf_we) begin
          chk("we_excl_req", mem_req, 0);
          chk("wr_expected", wr_q.size() > 0, 1);
          if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            chk("wr_idx", rf_add, w.idx);
            chk("wr_data", rf_wdata, w.data);
          end
        end
        if (done) begin
          chk("done_busy", busy, 0);
          chk("done_expected", done_q.size() > 0, 1);
          if (done_q.size() > 0) begin
            d = done_q.pop_front();
            chk("done_end_addr", end_addr, d.end_a);
            chk("done_latency", cyc - d.start_cyc, d.lat);
          end
          done_cnt++;
        end
        prev_stall = mem_req && !mem_ack;
        p_addr = mem_addr; p_wd = mem_wdata; p_we = mem_we; p_idx = rf_add;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic run_xfer(input logic d, input logic [7:0] m, input logic [31:0] b,
                          input int first_stall, input int stall_max, input bit poke);
    logic [7:0]  em;
    logic [31:0] a, exp_end;
    int n, st_tot, s, base_done;
    int unsigned lat;
`ifdef REG7_XFER_EN
    em = m;
`else
    em = m & 8'h7F;
`endif
    n = 0; st_tot = 0;
    for (int i = 0; i < 8; i++) begin
      if (em[i]) begin
        a = b + 32'(4 * n);
        if (n == 0 && first_stall >= 0) s = first_stall;
        else s = int'($urandom_range(0, stall_max));
        stall_q.push_back(s);
        st_tot += s;
        beat_q.push_back('{a, ~d, 3'(i), ref_regs[i]});
        if (d) begin
          wr_q.push_back('{3'(i), mem_read(a)});
          ref_regs[i] = mem_read(a);
        end
        n++;
      end
    end
    lat = d ? int'(2 * n + 1 + st_tot) : int'(n + 1 + st_tot);
    exp_end = b + 32'(4 * n);
    @(negedge clk);
    done_q.push_back('{exp_end, cyc, lat});
    base_done = done_cnt;
    start = 1'b1; dir = d; reg_mask = m; base_addr = b;
    @(negedge clk);
    start = poke; dir = 1'($urandom); reg_mask = 8'($urandom); base_addr = $urandom;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 400 && done_cnt == base_done; t++) @(negedge clk);
    chk("done_timeout", done_cnt != base_done, 1);
    repeat (2) @(negedge clk);
    chk("end_addr_hold", end_addr, exp_end);
  endtask

  initial begin
    logic [7:0] m;
    logic [31:0] b;
    rst = 1'b0; start = 1'b0; dir = 1'b0; reg_mask = 8'h00; base_addr = 32'h0;
    mon_en = 1'b0; preload = 1'b1;
    for (int i = 0; i < 8; i++) ref_regs[i] = $urandom;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_mem_req", mem_req, 0);
    chk("rst_rf_we", rf_we, 0); chk("rst_mem_addr", mem_addr, 0); chk("rst_end_addr", end_addr, 0);
    @(negedge clk);
    rst = 1'b1; preload = 1'b0; mon_en = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(1'b0, 8'h0B, 32'h0000_0100, 0, 0, 1'b0);
    run_xfer(1'b1, 8'h41, 32'h0000_0200, 0, 0, 1'b0);
    run_xfer(1'b0, 8'h00, 32'h0000_0040, 0, 0, 1'b0);
    run_xfer(1'b0, 8'h03, 32'hFFFF_FFFC, 3, 0, 1'b1);

    // Reset during load writeback: nothing may be written back.
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1; dir = 1'b1; reg_mask = 8'h06; base_addr = 32'h0000_0300;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 20 && !rf_we; t++) @(negedge clk);
    chk("rst_test_in_wb", rf_we, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk("arst_rf_we", rf_we, 0);
    chk("arst_mem_req", mem_req, 0); chk("arst_mem_we", mem_we, 0); chk("arst_rf_add", rf_add, 0);
    chk("arst_rf_wdata", rf_wdata, 0); chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0); chk("arst_end_addr", end_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    run_xfer(1'b1, 8'h06, 32'h0000_0300, 0, 0, 1'b0);
    run_xfer(1'b0, 8'hFF, 32'h0000_0000, 0, 0, 1'b0);
    run_xfer(1'b1, 8'h80, 32'h0000_0500, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0:       m = 8'h00;
        1:       m = 8'h80;
        default: m = 8'($urandom);
      endcase
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)) : $urandom;
      run_xfer(1'($urandom), m, b, -1, 2, 1'($urandom));
    end

    chk("beat_q_empty", beat_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("regfile_r%0d", i), regs[i], ref_regs[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
